// File: rtl/cnn_seq_pkg.sv
// Shared types for the CNN layer sequencer: FSM states, per-layer config record, field widths.
package cnn_seq_pkg;
  localparam int FILTERNUM_WIDTH = 8;
  localparam int KERNELNUM_WIDTH = 8;
  localparam int DATANUM_WIDTH   = 8;
  localparam int TIMESTEP_WIDTH  = 8;
  localparam int ADDR_WIDTH      = 10;
  localparam int WD_WIDTH        = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_REQ,
    S_HOLD,
    S_NEXT
  } seq_state_t;

  typedef struct packed {
    logic [FILTERNUM_WIDTH-1:0] num_filter;
    logic [KERNELNUM_WIDTH-1:0] num_kernel;
    logic [DATANUM_WIDTH-1:0]   filter_length;
    logic [TIMESTEP_WIDTH-1:0]  num_total_conv;
    logic [ADDR_WIDTH-1:0]      out_words;
  } layer_cfg_t;
endpackage

// File: rtl/cnn_seq_cfg_table.sv
// Layer configuration table: one synchronous write port, one combinational read port, cleared on reset.
import cnn_seq_pkg::*;

module cnn_seq_cfg_table #(
  parameter int MAX_LAYERS = 4,
  localparam int LW = $clog2(MAX_LAYERS)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_we,
  input  logic [LW-1:0] i_waddr,
  input  layer_cfg_t    i_wdata,
  input  logic [LW-1:0] i_raddr,
  output layer_cfg_t    o_rdata
);
  layer_cfg_t r_mem [MAX_LAYERS];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < MAX_LAYERS; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/cnn_layer_sequencer.sv
// Runs the layer table back-to-back: configure/enable the conv controller, count writes, stream results.
// Optional CNN_SEQ_WATCHDOG_EN: RUN idle watchdog with sticky o_err.
// IDLE wait start | LOAD latch entry, clear | RUN count writes | REQ present addr | HOLD offer word | NEXT advance layer
import cnn_seq_pkg::*;

module cnn_layer_sequencer #(
  parameter int MAX_LAYERS     = 4,
  parameter int MEM_DATA_WIDTH = 64,
  localparam int LW = $clog2(MAX_LAYERS)
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_cfg_we,
  input  logic [LW-1:0]              i_cfg_idx,
  input  logic [FILTERNUM_WIDTH-1:0] i_cfg_num_filter,
  input  logic [KERNELNUM_WIDTH-1:0] i_cfg_num_kernel,
  input  logic [DATANUM_WIDTH-1:0]   i_cfg_filter_length,
  input  logic [TIMESTEP_WIDTH-1:0]  i_cfg_num_total_conv,
  input  logic [ADDR_WIDTH-1:0]      i_cfg_out_words,
  input  logic [LW:0]                i_num_layers,
  input  logic                       i_start,
  output logic                       o_busy,
  output logic                       o_done,
`ifdef CNN_SEQ_WATCHDOG_EN
  output logic                       o_err,
`endif
  output logic                       o_ctrl_clear,
  output logic                       o_ctrl_enable,
  output logic [FILTERNUM_WIDTH-1:0] o_num_filter,
  output logic [KERNELNUM_WIDTH-1:0] o_num_kernel,
  output logic [DATANUM_WIDTH-1:0]   o_filter_length,
  output logic [TIMESTEP_WIDTH-1:0]  o_num_total_conv,
  input  logic                       i_ctrl_wen_n,
  output logic [ADDR_WIDTH-1:0]      o_mem_addr_b,
  output logic                       o_mem_wen_b,
  input  logic [MEM_DATA_WIDTH-1:0]  i_mem_out,
  output logic [MEM_DATA_WIDTH-1:0]  o_rd_data,
  output logic                       o_rd_valid,
  input  logic                       i_rd_ready,
  output logic                       o_rd_last
);
  seq_state_t            r_state, w_next;
  logic [LW:0]           r_layer, r_num_layers;
  layer_cfg_t            r_cfg, w_entry, w_wdata;
  logic [ADDR_WIDTH-1:0] r_wcnt, r_raddr;
  logic                  r_done_q;
  logic                  w_write, w_cfg_we, w_last_word, w_last_layer, w_wd_trip;

  assign w_write      = !i_ctrl_wen_n;
  assign w_cfg_we     = i_cfg_we && (r_state == S_IDLE);
  assign w_last_word  = (r_raddr == r_cfg.out_words - 1'b1);
  assign w_last_layer = ((r_layer + 1'b1) == r_num_layers);
  assign w_wdata      = '{i_cfg_num_filter, i_cfg_num_kernel, i_cfg_filter_length,
                          i_cfg_num_total_conv, i_cfg_out_words};

  cnn_seq_cfg_table #(.MAX_LAYERS(MAX_LAYERS)) u_cfg_table (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_we    (w_cfg_we),
    .i_waddr (i_cfg_idx),
    .i_wdata (w_wdata),
    .i_raddr (r_layer[LW-1:0]),
    .o_rdata (w_entry)
  );

`ifdef CNN_SEQ_WATCHDOG_EN
  logic [WD_WIDTH-1:0] r_idle;
  logic                r_err;
  assign w_wd_trip = (r_state == S_RUN) && !w_write && (r_idle == '1);
  assign o_err     = r_err;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_idle <= '0;
      r_err  <= 1'b0;
    end else begin
      if (r_state == S_IDLE && i_start) r_err <= 1'b0;
      if (r_state != S_RUN || w_write) r_idle <= '0;
      else if (r_idle != '1)           r_idle <= r_idle + 1'b1;
      if (w_wd_trip) r_err <= 1'b1;
    end
  end
`else
  assign w_wd_trip = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (i_start && i_num_layers != '0) w_next = S_LOAD;
      S_LOAD: w_next = (w_entry.out_words == '0) ? S_NEXT : S_RUN;
      S_RUN: begin
        if (w_write && (r_wcnt + 1'b1) == r_cfg.out_words) w_next = S_REQ;
        else if (w_wd_trip)                                 w_next = S_IDLE;
      end
      S_REQ:  w_next = S_HOLD;
      S_HOLD: if (i_rd_ready) w_next = w_last_word ? S_NEXT : S_REQ;
      S_NEXT: w_next = w_last_layer ? S_IDLE : S_LOAD;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_layer      <= '0;
      r_num_layers <= '0;
      r_cfg        <= '0;
      r_wcnt       <= '0;
      r_raddr      <= '0;
      r_done_q     <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_done_q <= w_wd_trip;
      case (r_state)
        S_IDLE: if (i_start) begin
          r_layer      <= '0;
          r_num_layers <= i_num_layers;
          if (i_num_layers == '0) r_done_q <= 1'b1;
        end
        S_LOAD: begin
          r_cfg   <= w_entry;
          r_wcnt  <= '0;
          r_raddr <= '0;
        end
        S_RUN:  if (w_write) r_wcnt <= r_wcnt + 1'b1;
        S_HOLD: if (i_rd_ready && !w_last_word) r_raddr <= r_raddr + 1'b1;
        S_NEXT: r_layer <= r_layer + 1'b1;
        default: ;
      endcase
    end
  end

  // rd_data is gated so the readout bus idles at zero outside HOLD
  assign o_busy           = (r_state != S_IDLE);
  assign o_done           = r_done_q || (r_state == S_NEXT && w_last_layer);
  assign o_ctrl_clear     = (r_state == S_LOAD);
  assign o_ctrl_enable    = (r_state == S_RUN);
  assign o_num_filter     = r_cfg.num_filter;
  assign o_num_kernel     = r_cfg.num_kernel;
  assign o_filter_length  = r_cfg.filter_length;
  assign o_num_total_conv = r_cfg.num_total_conv;
  assign o_mem_addr_b     = r_raddr;
  assign o_mem_wen_b      = 1'b1;
  assign o_rd_valid       = (r_state == S_HOLD);
  assign o_rd_last        = (r_state == S_HOLD) && w_last_word;
  assign o_rd_data        = (r_state == S_HOLD) ? i_mem_out : '0;
endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// Randomized bench for cnn_layer_sequencer against a job-level reference model and port-B memory model.
module tb_cnn_layer_sequencer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_cfg_we;
  logic [1:0]  i_cfg_idx;
  logic [7:0]  i_cfg_num_filter, i_cfg_num_kernel, i_cfg_filter_length, i_cfg_num_total_conv;
  logic [9:0]  i_cfg_out_words;
  logic [2:0]  i_num_layers;
  logic        i_start;
  logic        o_busy, o_done, o_ctrl_clear, o_ctrl_enable;
  logic [7:0]  o_num_filter, o_num_kernel, o_filter_length, o_num_total_conv;
  logic        i_ctrl_wen_n;
  logic [9:0]  o_mem_addr_b;
  logic        o_mem_wen_b;
  logic [63:0] i_mem_out, o_rd_data;
  logic        o_rd_valid, i_rd_ready, o_rd_last;
`ifdef CNN_SEQ_WATCHDOG_EN
  logic        o_err;
`endif

  cnn_layer_sequencer dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_cfg_we(i_cfg_we), .i_cfg_idx(i_cfg_idx),
    .i_cfg_num_filter(i_cfg_num_filter), .i_cfg_num_kernel(i_cfg_num_kernel),
    .i_cfg_filter_length(i_cfg_filter_length), .i_cfg_num_total_conv(i_cfg_num_total_conv),
    .i_cfg_out_words(i_cfg_out_words), .i_num_layers(i_num_layers), .i_start(i_start),
    .o_busy(o_busy), .o_done(o_done),
`ifdef CNN_SEQ_WATCHDOG_EN
    .o_err(o_err),
`endif
    .o_ctrl_clear(o_ctrl_clear), .o_ctrl_enable(o_ctrl_enable),
    .o_num_filter(o_num_filter), .o_num_kernel(o_num_kernel),
    .o_filter_length(o_filter_length), .o_num_total_conv(o_num_total_conv),
    .i_ctrl_wen_n(i_ctrl_wen_n), .o_mem_addr_b(o_mem_addr_b), .o_mem_wen_b(o_mem_wen_b),
    .i_mem_out(i_mem_out), .o_rd_data(o_rd_data), .o_rd_valid(o_rd_valid),
    .i_rd_ready(i_rd_ready), .o_rd_last(o_rd_last)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;
  int exp_clr = 0;
  int busy_cyc = 0;
  logic [31:0] salt;
  logic [15:0] clr_cnt = '0;

  // reference table contents
  logic [7:0] m_nf [4];
  logic [7:0] m_nk [4];
  logic [7:0] m_fl [4];
  logic [7:0] m_tc [4];
  logic [9:0] m_ow [4];

  function automatic logic [63:0] mem_word(input logic [15:0] c, input logic [9:0] a);
    return {salt, c, 6'd0, a};
  endfunction

  // port-B memory: registered read, content tagged with the layer-load count
  always @(posedge clk) begin
    if (o_ctrl_clear) clr_cnt <= clr_cnt + 16'd1;
    i_mem_out <= mem_word(clr_cnt, o_mem_addr_b);
    if (o_busy) busy_cyc <= busy_cyc + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      m_nf[i] = '0; m_nk[i] = '0; m_fl[i] = '0; m_tc[i] = '0; m_ow[i] = '0;
    end
  endtask

  task automatic drive_cfg(input int idx, input int ow);
    i_cfg_we             = 1'b1;
    i_cfg_idx            = 2'(idx);
    i_cfg_num_filter     = 8'($urandom);
    i_cfg_num_kernel     = 8'($urandom);
    i_cfg_filter_length  = 8'($urandom);
    i_cfg_num_total_conv = 8'($urandom);
    i_cfg_out_words      = 10'(ow);
  endtask

  task automatic write_cfg(input int idx, input int ow);
    drive_cfg(idx, ow);
    m_nf[idx] = i_cfg_num_filter; m_nk[idx] = i_cfg_num_kernel;
    m_fl[idx] = i_cfg_filter_length; m_tc[idx] = i_cfg_num_total_conv; m_ow[idx] = 10'(ow);
    tick();
    i_cfg_we = 1'b0;
  endtask

  task automatic run_job(input int n, input int stall5, input bit wr_at_start, input bit wr_busy);
    int exp_len, b0, gap, st;
    bit first_word;
    first_word = 1'b1;
    exp_len = 0;
    check("pre_busy", o_busy, 0);
    if (wr_at_start) begin
      drive_cfg(0, $urandom_range(1, 3));
      m_nf[0] = i_cfg_num_filter; m_nk[0] = i_cfg_num_kernel;
      m_fl[0] = i_cfg_filter_length; m_tc[0] = i_cfg_num_total_conv; m_ow[0] = i_cfg_out_words;
    end
    b0 = busy_cyc;
    i_num_layers = 3'(n);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    i_cfg_we = 1'b0;
    for (int l = 0; l < n; l++) begin
      check("load_clear", o_ctrl_clear, 1);
      check("load_busy", o_busy, 1);
      check("load_en", o_ctrl_enable, 0);
      exp_clr++;
      exp_len += 2;
      tick();
      if (m_ow[l] != 0) begin
        check("cfg_out", {o_num_filter, o_num_kernel, o_filter_length, o_num_total_conv},
              {m_nf[l], m_nk[l], m_fl[l], m_tc[l]});
        for (int k = 0; k < int'(m_ow[l]); k++) begin
          gap = (wr_busy && l == 0 && k == 0) ? 2 : $urandom_range(0, 2);
          for (int g = 0; g < gap; g++) begin
            check("run_en", o_ctrl_enable, 1);
            if (wr_busy && l == 0) drive_cfg(2, 7);
            tick();
            i_cfg_we = 1'b0;
          end
          check("run_en_w", o_ctrl_enable, 1);
          i_ctrl_wen_n = 1'b0;
          tick();
          i_ctrl_wen_n = 1'b1;
          exp_len += gap + 1;
        end
        check("en_drop", o_ctrl_enable, 0);
        for (int a = 0; a < int'(m_ow[l]); a++) begin
          check("req_addr", o_mem_addr_b, 64'(a));
          check("req_valid", o_rd_valid, 0);
          tick();
          st = first_word ? stall5 : $urandom_range(0, 2);
          first_word = 1'b0;
          for (int s = 0; s <= st; s++) begin
            check("hold_valid", o_rd_valid, 1);
            check("hold_data", o_rd_data, mem_word(16'(exp_clr), 10'(a)));
            check("hold_addr", o_mem_addr_b, 64'(a));
            check("hold_last", o_rd_last, (a == int'(m_ow[l]) - 1) ? 1 : 0);
            i_rd_ready = (s == st);
            tick();
            i_rd_ready = 1'b0;
          end
          exp_len += 2 + st;
        end
      end else begin
        check("skip_valid", o_rd_valid, 0);
        check("skip_en", o_ctrl_enable, 0);
      end
      check("next_done", o_done, (l == n - 1) ? 1 : 0);
      if (l != n - 1) tick();
    end
    tick();
    check("post_busy", o_busy, 0);
    check("post_done", o_done, 0);
    check("job_len", 64'(busy_cyc - b0), 64'(exp_len));
    check("cfg_hold", {o_num_filter, o_num_kernel, o_filter_length, o_num_total_conv},
          {m_nf[n-1], m_nk[n-1], m_fl[n-1], m_tc[n-1]});
  endtask

  initial begin
    salt = $urandom;
    rst_n = 1'b0;
    i_cfg_we = 1'b0; i_cfg_idx = '0;
    i_cfg_num_filter = '0; i_cfg_num_kernel = '0; i_cfg_filter_length = '0;
    i_cfg_num_total_conv = '0; i_cfg_out_words = '0;
    i_num_layers = '0; i_start = 1'b0; i_ctrl_wen_n = 1'b1; i_rd_ready = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    i_start = 1'b1; i_num_layers = 3'd1;
    tick();
    check("rst_busy", o_busy, 0);
    check("rst_wen_b", o_mem_wen_b, 1);
    check("rst_outs", {o_done, o_ctrl_clear, o_ctrl_enable, o_num_filter, o_num_kernel,
                       o_filter_length, o_num_total_conv, o_mem_addr_b, o_rd_valid, o_rd_last}, 0);
    check("rst_data", o_rd_data, 0);
    i_start = 1'b0;
    rst_n = 1'b1;
    tick();
    check("idle_busy", o_busy, 0);

    write_cfg(0, 3);
    run_job(1, 0, 1'b0, 1'b0);

    write_cfg(0, $urandom_range(1, 4));
    write_cfg(1, $urandom_range(1, 4));
    run_job(2, 0, 1'b0, 1'b0);
    run_job(2, 5, 1'b0, 1'b0);

    i_num_layers = 3'd0; i_start = 1'b1;
    tick();
    i_start = 1'b0;
    check("zero_done", o_done, 1);
    check("zero_busy", o_busy, 0);
    check("zero_en", o_ctrl_enable, 0);
    tick();
    check("zero_done_off", o_done, 0);

    write_cfg(0, $urandom_range(1, 3));
    write_cfg(1, 0);
    write_cfg(2, $urandom_range(1, 3));
    run_job(3, 0, 1'b0, 1'b1);

    run_job(1, 0, 1'b1, 1'b0);

    write_cfg(0, 3);
    i_num_layers = 3'd2; i_start = 1'b1;
    tick();
    i_start = 1'b0;
    tick();
    exp_clr++;
    check("abort_run", o_ctrl_enable, 1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", o_busy, 0);
    check("abort_done", o_done, 0);
    check("abort_en", o_ctrl_enable, 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    tick();
    check("abort_idle", o_busy, 0);

    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < 4; i++) write_cfg(i, $urandom_range(0, 4));
      run_job($urandom_range(1, 4), $urandom_range(0, 3), 1'b0, 1'b0);
    end

`ifdef CNN_SEQ_WATCHDOG_EN
    begin
      bit seen;
      int waited;
      seen = 1'b0;
      waited = 0;
      write_cfg(0, 2);
      i_num_layers = 3'd1; i_start = 1'b1;
      tick();
      i_start = 1'b0;
      exp_clr++;
      while (!seen && waited < 70000) begin
        tick();
        waited++;
        if (o_done) seen = 1'b1;
      end
      check("wd_done", seen, 1);
      check("wd_err", o_err, 1);
      check("wd_en", o_ctrl_enable, 0);
      i_num_layers = 3'd0; i_start = 1'b1;
      tick();
      i_start = 1'b0;
      check("wd_err_clr", o_err, 0);
    end
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule

// File: doc/cnn_layer_sequencer.md
# cnn_layer_sequencer

Multi-layer job scheduler for the CNN accelerator. Holds a small table of per-layer convolution configurations and runs them back-to-back. For each layer it drives the convolution controller's configuration and enable, counts output-memory writes to detect layer completion, then streams that layer's results out of output-memory port B over a valid/ready interface. It sits between the host/config bus and the controller, pe_array and output-memory pair.

## Interface
- MAX_LAYERS, 4, depth of the layer configuration table
- FILTERNUM_WIDTH / KERNELNUM_WIDTH / DATANUM_WIDTH / TIMESTEP_WIDTH, 8 each, widths of the controller config fields
- ADDR_WIDTH, 10, output-memory address width
- MEM_DATA_WIDTH, 64, output-memory word width
- LW, $clog2(MAX_LAYERS), layer index width
---
- clk  in  1  clock; single clock domain
- reset  in  1  asynchronous, active-low reset
- cfg_we  in  1  write one table entry; ignored while busy
- cfg_idx  in  LW  entry written
- cfg_num_filter / cfg_num_kernel / cfg_filter_length / cfg_num_total_conv  in  field widths  layer config
- cfg_out_words  in  ADDR_WIDTH  output words the layer produces
- num_layers  in  LW+1  layers to run; sampled on start
- start  in  1  single-cycle start; ignored unless IDLE
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle pulse when the job ends
- ctrl_clear  out  1  synchronous clear to controller and pe_array
- ctrl_enable  out  1  enable to controller and pe_array
- num_filter / num_kernel / filter_length / num_total_conv  out  field widths  active layer config
- ctrl_wen_n  in  1  controller's output-memory port-A write enable, active-low
- mem_addr_b  out  ADDR_WIDTH  port-B address
- mem_wen_b  out  1  port-B write enable, active-low; constant 1 (read only)
- mem_out  in  MEM_DATA_WIDTH  port-B read data, valid one cycle after the address
- rd_data  out  MEM_DATA_WIDTH  readout data (equals mem_out)
- rd_valid / rd_ready / rd_last  out/in/out  1  readout handshake; rd_last marks the final word of a layer

## Operation
- States: IDLE, LOAD, RUN, REQ, HOLD, NEXT.
- IDLE:
  - start with num_layers == 0: done pulses the next cycle and the block stays IDLE.
  - start otherwise: layer = 0, go to LOAD.
- LOAD (1 cycle):
  - Config outputs take entry[layer].
  - ctrl_clear = 1; write counter wcnt = 0.
  - If cfg_out_words == 0, go to NEXT; otherwise go to RUN.
- RUN:
  - ctrl_enable = 1.
  - Each cycle with ctrl_wen_n == 0 increments wcnt.
  - The cycle wcnt reaches out_words: ctrl_enable drops and the block goes to REQ with raddr = 0.
  - Writes beyond out_words are not counted.
- REQ: mem_addr_b = raddr; go to HOLD.
- HOLD:
  - rd_valid = 1; rd_data = mem_out; mem_addr_b stays at raddr.
  - rd_last = (raddr == out_words−1).
  - On rd_ready: if rd_last, go to NEXT; otherwise raddr+1 and go to REQ.
  - rd_valid stays high and rd_data stays stable until accepted.
- NEXT:
  - layer+1; if layer+1 == num_layers, pulse done and go to IDLE; otherwise go to LOAD.
- Config outputs hold their value between LOAD events. They are not cleared at the end of a job.
- Table entries default to all-zero at reset.
- Same-cycle cfg_we and start in IDLE: the write lands and the job runs with the new value.

## Timing
- Reset values: all outputs 0 except mem_wen_b = 1. State = IDLE, table cleared. Reset mid-job aborts immediately, with no done pulse.
- start → busy at +1 cycle; LOAD at +1; RUN at +2.
- Readout throughput is 1 word per 2 cycles with rd_ready held high. Backpressure adds 1 cycle per stalled cycle.
- done occurs 1 cycle after the final rd_last handshake. The next start can be accepted in the cycle following done.

## Configuration
- CNN_SEQ_WATCHDOG_EN:
  - Defined: a 16-bit idle counter in RUN is reset by every write. When it saturates at 0xFFFF, the job aborts: ctrl_enable drops, a sticky output err (1 bit, cleared on start) sets, and done pulses.
  - Undefined: no err port; RUN waits indefinitely.

## Structure
- Package cnn_seq_pkg holds:
  - the state enum;
  - layer_cfg_t struct {num_filter, num_kernel, filter_length, num_total_conv, out_words};
  - the watchdog width constant.
- Sub-module cnn_seq_cfg_table: MAX_LAYERS×layer_cfg_t register file with one write port and one combinational read port.

## Test plan
- Reset held low: all outputs at reset values, mem_wen_b = 1. Pulse start during reset → busy stays 0.
- 1 layer, out_words = 3: inject 3 writes → ctrl_enable falls the cycle of the third write. Addresses 0, 1, 2 are read; rd_last is set on address 2; done pulses 1 cycle after that handshake.
- 2 layers with different configs: config outputs change at the second LOAD, with a ctrl_clear pulse each time. The readout yields 2 word sequences.
- rd_ready low for 5 cycles in HOLD: rd_valid and rd_data stay stable and mem_addr_b stays unchanged. Total job length grows by exactly 5 cycles.
- num_layers = 0 → done at +1 with no ctrl_enable. A layer with out_words = 0 is skipped with no readout.
- With CNN_SEQ_WATCHDOG_EN: no writes in RUN → err = 1 and done after 65535 idle cycles. A new start clears err.
